// File: rtl/trace_ctrl.sv
// -----------------------------------------------------------------------------
// trace_ctrl
//   Run/stop controller for the RAM tracer. Config-bus writes land in control,
//   trigger-address and capture-limit registers. An IDLE/ARMED/TRACING/DONE
//   sequencer drives the tracer enables. START/STOP marker packets are merged
//   into the tracer packet stream on its way to usb_comm.
//
// Ports
//   mclk, reset            clock, synchronous active-high reset
//   config_addr/data/strobe config bus write (regs at BASE_ADDR..BASE_ADDR+3)
//   filter_strobe, filter_addr_latch, filter_a
//                          RAM sample snoop used for the trigger match
//   trace_pkt_strobe/type/payload
//                          packets from the tracer state machine
//   trace_enable, trace_reads
//                          enables back to the tracer
//   packet_strobe/type/payload
//                          merged packet stream, registered, to usb_comm
//   trace_state            00 IDLE, 01 ARMED, 10 TRACING, 11 DONE
//   pkt_count              tracer packets seen while TRACING (saturating)
// -----------------------------------------------------------------------------
module trace_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [15:0] config_addr,
  input  logic [15:0] config_data,
  input  logic        config_strobe,
  input  logic        filter_strobe,
  input  logic        filter_addr_latch,
  input  logic [22:0] filter_a,
  input  logic        trace_pkt_strobe,
  input  logic [1:0]  trace_pkt_type,
  input  logic [22:0] trace_pkt_payload,
  output logic        trace_enable,
  output logic        trace_reads,
  output logic        packet_strobe,
  output logic [1:0]  packet_type,
  output logic [22:0] packet_payload,
  output logic [1:0]  trace_state,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_TRACING = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] PKT_MARKER = 2'b11;
  localparam logic [1:0] KIND_START = 2'b00;
  localparam logic [1:0] KIND_LIMIT = 2'b01;
  localparam logic [1:0] KIND_STOP  = 2'b10;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Type-11 payloads with bit 22 set would look like markers; clamp them.
  function automatic logic [22:0] sat_payload(input logic [1:0] t, input logic [22:0] p);
    return (t == PKT_MARKER && p[22]) ? 23'h3FFFFF : p;
  endfunction

  function automatic logic [22:0] make_marker(input logic [1:0] kind, input logic [15:0] d);
    return {1'b1, kind, 4'b0000, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: config-bus decode. CTRL writes are registered and acted on by
  // the sequencer one cycle later; the other registers take effect directly.
  // ---------------------------------------------------------------------------
  logic        ctrl_wr_p0;
  logic        ctrl_arm_p0;
  logic        ctrl_stop_p0;
  logic        ctrl_trig_p0;
  logic [22:0] trig_a;
  logic [15:0] limit;

  always_ff @(posedge mclk) begin
    if (reset) begin
      ctrl_wr_p0   <= 1'b0;
      ctrl_arm_p0  <= 1'b0;
      ctrl_stop_p0 <= 1'b0;
      ctrl_trig_p0 <= 1'b0;
      trig_a       <= '0;
      limit        <= '0;
      trace_reads  <= 1'b0;
    end else begin
      ctrl_wr_p0 <= 1'b0;
      if (config_strobe) begin
        if (config_addr == BASE_ADDR) begin
          ctrl_wr_p0   <= 1'b1;
          ctrl_arm_p0  <= config_data[0];
          ctrl_stop_p0 <= config_data[2];
          ctrl_trig_p0 <= config_data[3];
          trace_reads  <= config_data[1];
        end else if (config_addr == BASE_ADDR + 16'd1) begin
          trig_a[15:0] <= config_data;
        end else if (config_addr == BASE_ADDR + 16'd2) begin
          trig_a[22:16] <= config_data[6:0];
        end else if (config_addr == BASE_ADDR + 16'd3) begin
          limit <= config_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: sequencer, packet counter and merge.
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [15:0] cnt_nxt;
  logic [15:0] cnt_inc;
  logic        cnt_step;
  logic        limit_hit;
  logic        stop_cmd, arm_cmd, idle_cmd, trig_hit;
  logic [1:0]  stop_kind;

  logic        pend_vld, pend_vld_nxt;
  logic [22:0] pend_pl, pend_pl_nxt;
  logic        mk_vld;
  logic [22:0] mk_pl;
  logic        out_vld;
  logic [1:0]  out_type;
  logic [22:0] out_pl;

  // State register. trace_enable is registered from the next state so that
  // it tracks state==TRACING exactly.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      trace_enable <= 1'b0;
    end else begin
      state        <= state_nxt;
      trace_enable <= (state_nxt == ST_TRACING);
    end
  end

  // Next-state logic.
  always_comb begin
    cnt_inc   = sat_inc(pkt_count);
    cnt_step  = (state == ST_TRACING) && trace_pkt_strobe;
    limit_hit = cnt_step && (limit != 16'd0) && (cnt_inc == limit);
    // STOP beats ARM; ARM is refused while a marker is still waiting to go out.
    stop_cmd  = ctrl_wr_p0 && ctrl_stop_p0;
    arm_cmd   = ctrl_wr_p0 && ctrl_arm_p0 && !ctrl_stop_p0 && !pend_vld;
    idle_cmd  = ctrl_wr_p0 && !ctrl_arm_p0 && !ctrl_stop_p0;
    trig_hit  = filter_strobe && filter_addr_latch && (filter_a == trig_a);

    state_nxt = state;
    stop_kind = KIND_STOP;
    cnt_nxt   = cnt_step ? cnt_inc : pkt_count;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (idle_cmd) begin
          state_nxt = ST_IDLE;
        end else if (arm_cmd) begin
          state_nxt = ctrl_trig_p0 ? ST_ARMED : ST_TRACING;
          cnt_nxt   = 16'd0;
        end
      end
      ST_ARMED: begin
        // A write that changes state takes precedence over a same-cycle trigger.
        if (idle_cmd)      state_nxt = ST_IDLE;
        else if (trig_hit) state_nxt = ST_TRACING;
      end
      ST_TRACING: begin
        if (limit_hit) begin
          state_nxt = ST_DONE;
          stop_kind = KIND_LIMIT;
        end else if (stop_cmd) begin
          state_nxt = ST_DONE;
          stop_kind = KIND_STOP;
        end else if (idle_cmd) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: marker generation and merge priority.
  always_comb begin
    mk_vld = 1'b0;
    mk_pl  = '0;
    if (state_nxt == ST_TRACING && state != ST_TRACING) begin
      mk_vld = 1'b1;
      mk_pl  = make_marker(KIND_START, {15'b0, (state == ST_ARMED)});
    end else if (state == ST_TRACING && state_nxt == ST_DONE) begin
      mk_vld = 1'b1;
      mk_pl  = make_marker(stop_kind, cnt_nxt);
    end

    out_vld      = 1'b0;
    out_type     = 2'b00;
    out_pl       = '0;
    pend_vld_nxt = pend_vld;
    pend_pl_nxt  = pend_pl;

    if (trace_pkt_strobe) begin
      // Tracer always wins the slot; a fresh marker is parked if the single
      // pending slot is free, otherwise the older marker keeps it.
      out_vld  = 1'b1;
      out_type = trace_pkt_type;
      out_pl   = sat_payload(trace_pkt_type, trace_pkt_payload);
      if (!pend_vld && mk_vld) begin
        pend_vld_nxt = 1'b1;
        pend_pl_nxt  = mk_pl;
      end
    end else if (pend_vld) begin
      out_vld  = 1'b1;
      out_type = PKT_MARKER;
      out_pl   = pend_pl;
      pend_vld_nxt = mk_vld;
      pend_pl_nxt  = mk_vld ? mk_pl : pend_pl;
    end else if (mk_vld) begin
      out_vld  = 1'b1;
      out_type = PKT_MARKER;
      out_pl   = mk_pl;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      pkt_count      <= '0;
      pend_vld       <= 1'b0;
      pend_pl        <= '0;
      packet_strobe  <= 1'b0;
      packet_type    <= 2'b00;
      packet_payload <= '0;
    end else begin
      pkt_count      <= cnt_nxt;
      pend_vld       <= pend_vld_nxt;
      pend_pl        <= pend_pl_nxt;
      packet_strobe  <= out_vld;
      packet_type    <= out_type;
      packet_payload <= out_pl;
    end
  end

  assign trace_state = state;

endmodule

// File: tb/tb_trace_ctrl.sv
module tb_trace_ctrl;

  logic        mclk = 1'b0;
  logic        reset;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic        filter_strobe;
  logic        filter_addr_latch;
  logic [22:0] filter_a;
  logic        trace_pkt_strobe;
  logic [1:0]  trace_pkt_type;
  logic [22:0] trace_pkt_payload;
  logic        trace_enable;
  logic        trace_reads;
  logic        packet_strobe;
  logic [1:0]  packet_type;
  logic [22:0] packet_payload;
  logic [1:0]  trace_state;
  logic [15:0] pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  trace_ctrl #(.BASE_ADDR(16'h0010)) dut (
    .mclk              (mclk),
    .reset             (reset),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .config_strobe     (config_strobe),
    .filter_strobe     (filter_strobe),
    .filter_addr_latch (filter_addr_latch),
    .filter_a          (filter_a),
    .trace_pkt_strobe  (trace_pkt_strobe),
    .trace_pkt_type    (trace_pkt_type),
    .trace_pkt_payload (trace_pkt_payload),
    .trace_enable      (trace_enable),
    .trace_reads       (trace_reads),
    .packet_strobe     (packet_strobe),
    .packet_type       (packet_type),
    .packet_payload    (packet_payload),
    .trace_state       (trace_state),
    .pkt_count         (pkt_count)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] a, input logic [15:0] d);
    config_addr   = a;
    config_data   = d;
    config_strobe = 1'b1;
    step();
    config_strobe = 1'b0;
  endtask

  task automatic pkt(input logic v, input logic [1:0] t, input logic [22:0] p);
    trace_pkt_strobe  = v;
    trace_pkt_type    = t;
    trace_pkt_payload = p;
  endtask

  initial begin
    reset = 1'b1;
    config_addr = '0; config_data = '0; config_strobe = 1'b0;
    filter_strobe = 1'b0; filter_addr_latch = 1'b0; filter_a = '0;
    pkt(1'b0, 2'b00, 23'h0);
    step();
    step();

    // Reset state
    chk("rst_state",  trace_state,   2'b00);
    chk("rst_enable", trace_enable,  1'b0);
    chk("rst_reads",  trace_reads,   1'b0);
    chk("rst_strobe", packet_strobe, 1'b0);
    chk("rst_count",  pkt_count,     16'd0);
    reset = 1'b0;
    step();

    // 1: plain ARM -> TRACING two cycles after the strobe, START marker
    cfg(16'h0010, 16'h0001);
    chk("t1_en_early", trace_enable, 1'b0);
    step();
    chk("t1_en",      trace_enable,   1'b1);
    chk("t1_state",   trace_state,    2'b10);
    chk("t1_strobe",  packet_strobe,  1'b1);
    chk("t1_type",    packet_type,    2'b11);
    chk("t1_payload", packet_payload, 23'h400000);
    step();
    chk("t1_quiet",   packet_strobe,  1'b0);
    chk("t1_pl_zero", packet_payload, 23'h0);

    // 5: pass-through payload clamp on type 11 only
    pkt(1'b1, 2'b11, 23'h7FFFFF);
    step();
    chk("t5_strobe", packet_strobe,  1'b1);
    chk("t5_type11", packet_type,    2'b11);
    chk("t5_sat",    packet_payload, 23'h3FFFFF);
    chk("t5_cnt1",   pkt_count,      16'd1);
    pkt(1'b1, 2'b01, 23'h7FFFFF);
    step();
    chk("t5_type01",  packet_type,    2'b01);
    chk("t5_pass01",  packet_payload, 23'h7FFFFF);
    pkt(1'b1, 2'b10, 23'h7FFFFF);
    step();
    chk("t5_pass10",  packet_payload, 23'h7FFFFF);
    pkt(1'b1, 2'b11, 23'h3FFFFF);
    step();
    chk("t5_edge",    packet_payload, 23'h3FFFFF);
    chk("t5_cnt4",    pkt_count,      16'd4);
    pkt(1'b0, 2'b00, 23'h0);
    step();
    chk("t5_quiet",   packet_strobe,  1'b0);

    // 4: STOP write, marker collides with tracer packets for two cycles
    cfg(16'h0010, 16'h0004);
    pkt(1'b1, 2'b01, 23'h000AAA);
    step();
    chk("t4_state",   trace_state,    2'b11);
    chk("t4_en",      trace_enable,   1'b0);
    chk("t4_pkt1",    packet_payload, 23'h000AAA);
    chk("t4_type1",   packet_type,    2'b01);
    chk("t4_cnt",     pkt_count,      16'd5);
    pkt(1'b1, 2'b01, 23'h000BBB);
    step();
    chk("t4_pkt2",    packet_payload, 23'h000BBB);
    chk("t4_cnt_hold", pkt_count,     16'd5);
    pkt(1'b0, 2'b00, 23'h0);
    step();
    chk("t4_mk_strobe", packet_strobe,  1'b1);
    chk("t4_mk_type",   packet_type,    2'b11);
    chk("t4_mk_pl",     packet_payload, 23'h600005);
    step();
    chk("t4_quiet",     packet_strobe,  1'b0);

    // READS bit and STOP ignored outside TRACING
    cfg(16'h0010, 16'h0006);
    chk("reads_on",   trace_reads, 1'b1);
    step();
    chk("stop_ign",   trace_state, 2'b11);

    // 2: triggered capture
    cfg(16'h0011, 16'h1234);
    cfg(16'h0012, 16'h0005);
    cfg(16'h0010, 16'h0009);
    chk("t2_reads_off", trace_reads, 1'b0);
    step();
    chk("t2_armed",   trace_state,   2'b01);
    chk("t2_en",      trace_enable,  1'b0);
    chk("t2_cnt_clr", pkt_count,     16'd0);
    chk("t2_nomk",    packet_strobe, 1'b0);
    filter_strobe = 1'b1; filter_addr_latch = 1'b0; filter_a = 23'h051234;
    step();
    chk("t2_nolatch", trace_state, 2'b01);
    filter_addr_latch = 1'b1; filter_a = 23'h051235;
    step();
    chk("t2_miss",    trace_state, 2'b01);
    filter_a = 23'h051234;
    step();
    filter_strobe = 1'b0; filter_addr_latch = 1'b0;
    chk("t2_state",   trace_state,    2'b10);
    chk("t2_en_on",   trace_enable,   1'b1);
    chk("t2_mk_type", packet_type,    2'b11);
    chk("t2_mk_pl",   packet_payload, 23'h400001);

    // 3: limit of three packets
    cfg(16'h0013, 16'h0003);
    pkt(1'b1, 2'b01, 23'h000001);
    step();
    chk("t3_cnt1",  pkt_count,   16'd1);
    pkt(1'b1, 2'b01, 23'h000002);
    step();
    chk("t3_run",   trace_state, 2'b10);
    pkt(1'b1, 2'b01, 23'h000003);
    step();
    chk("t3_done",  trace_state,    2'b11);
    chk("t3_en",    trace_enable,   1'b0);
    chk("t3_cnt3",  pkt_count,      16'd3);
    chk("t3_pkt3",  packet_payload, 23'h000003);
    chk("t3_type3", packet_type,    2'b01);
    pkt(1'b0, 2'b00, 23'h0);
    step();
    chk("t3_mk_type", packet_type,    2'b11);
    chk("t3_mk_pl",   packet_payload, 23'h500003);
    step();

    // 6: reset while a START marker is pending
    pkt(1'b1, 2'b10, 23'h000123);
    cfg(16'h0010, 16'h0001);
    step();
    chk("t6_en",     trace_enable,   1'b1);
    chk("t6_tracer", packet_payload, 23'h000123);
    chk("t6_type",   packet_type,    2'b10);
    reset = 1'b1;
    step();
    chk("t6_strobe",  packet_strobe,  1'b0);
    chk("t6_ptype",   packet_type,    2'b00);
    chk("t6_payload", packet_payload, 23'h0);
    chk("t6_state",   trace_state,    2'b00);
    chk("t6_en_off",  trace_enable,   1'b0);
    chk("t6_cnt",     pkt_count,      16'd0);
    reset = 1'b0;
    pkt(1'b0, 2'b00, 23'h0);
    step();
    chk("t6_nomk",    packet_strobe,  1'b0);
    step();
    chk("t6_nomk2",   packet_strobe,  1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
